// File: rtl/chunked_seq_adder.sv
// chunked_seq_adder: width-bit a+b+cin over a chunk-bit adder, one chunk per cycle, LSB first.
module chunked_seq_adder #(
    parameter int width = 32,
    parameter int chunk = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] s,
    output logic             cout
);
    localparam int n  = width / chunk;
    localparam int cw = (n > 1) ? $clog2(n) : 1;

    if (chunk < 1 || chunk > width || width % chunk != 0) begin : g_bad_param
        $error("chunked_seq_adder: width must be a positive multiple of chunk");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [cw-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [width-1:0]  a_q, a_d, b_q, b_d, s_q, s_d;
    logic              cout_q, cout_d;
    logic [chunk:0]    sum;

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign s         = s_q;
    assign cout      = cout_q;

    // Carry is extracted from the full chunk+1 bit sum before anything is truncated.
    assign sum = {1'b0, a_q[chunk-1:0]} + {1'b0, b_q[chunk-1:0]} + (chunk+1)'(carry_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = b;
                carry_d = cin;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                s_d     = (s_q >> chunk) | (width'(sum[chunk-1:0]) << (width - chunk));
                carry_d = sum[chunk];
                a_d     = a_q >> chunk;
                b_d     = b_q >> chunk;
                if (cnt_q == cw'(n - 1)) begin
                    cout_d  = sum[chunk];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + cw'(1);
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end
endmodule

// File: tb/tb_chunked_seq_adder.sv
// tb_chunked_seq_adder: directed vectors on a 32/8 instance plus random sweeps on 32/32, 32/1, 16/4.
module tb_chunked_seq_adder;
    logic        clock, reset, in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [31:0] a, b, s;
    logic        sw_reset;
    logic [2:0]  sw_done;
    int          vectors, miscompares;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] s;
        logic        cout;
    } vec_t;
    vec_t tbl[7];

    chunked_seq_adder #(.width(32), .chunk(8)) u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts at a negedge with the DUT idle; returns at the negedge where out_valid is seen.
    task automatic op(input logic [31:0] ta, input logic [31:0] tb_, input logic tc, output int lat);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clock);
        in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
    endtask

    initial begin
        int lat;
        vectors = 0; miscompares = 0;
        tbl[0] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
        tbl[1] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0};
        tbl[2] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        tbl[3] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        tbl[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        tbl[5] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
        tbl[6] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0};
        reset = 1'b0; in_valid = 1'b1; out_ready = 1'b0; a = 32'h1; b = 32'h1; cin = 1'b0;
        repeat (3) @(negedge clock);
        check("reset state {in_ready,out_valid,cout,s}", {in_ready, out_valid, cout, s}, {1'b1, 1'b0, 1'b0, 32'h0});
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clock);
        check("idle after reset in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 7; i++) begin
            op(tbl[i].a, tbl[i].b, tbl[i].cin, lat);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'd5);
            check($sformatf("vec%0d sum", i), {cout, s}, {tbl[i].cout, tbl[i].s});
            out_ready = 1'b1;
            @(negedge clock);
            out_ready = 1'b0;
            check($sformatf("vec%0d back to idle", i), {in_ready, out_valid}, 2'b10);
        end
        // Back-pressure: result must hold and new operands must be refused.
        op(32'd1, 32'd2, 1'b0, lat);
        for (int i = 0; i < 6; i++) begin
            in_valid = (i == 2 || i == 3); a = 32'd100; b = 32'd100;
            check($sformatf("hold cycle %0d", i), {out_valid, in_ready, cout, s}, {1'b1, 1'b0, 1'b0, 32'd3});
            @(negedge clock);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("hold end", {out_valid, in_ready, cout, s}, {1'b1, 1'b0, 1'b0, 32'd3});
        @(negedge clock);
        out_ready = 1'b0;
        check("release to idle, result kept", {out_valid, in_ready, cout, s}, {1'b0, 1'b1, 1'b0, 32'd3});
        // Reset after two RUN chunks of a long carry ripple.
        a = 32'hFFFFFFFF; b = 32'h0; cin = 1'b1; in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("mid-op reset", {in_ready, out_valid, cout, s}, {1'b1, 1'b0, 1'b0, 32'h0});
        op(32'd5, 32'd7, 1'b0, lat);
        check("post-reset latency", 64'(lat), 64'd5);
        check("post-reset sum", {cout, s}, {1'b0, 32'd12});
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        wait (&sw_done);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        sw_reset = 1'b0;
        repeat (2) @(negedge clock);
        sw_reset = 1'b1;
    end

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int W = (g == 2) ? 16 : 32;
        localparam int C = (g == 0) ? 32 : (g == 1) ? 1 : 4;
        localparam int N = W / C;
        logic         rv, rir, rc, rov, rr, rcout;
        logic [W-1:0] ra, rb, rs;

        chunked_seq_adder #(.width(W), .chunk(C)) u_sw (
            .clock(clock), .reset(sw_reset), .in_valid(rv), .in_ready(rir),
            .a(ra), .b(rb), .cin(rc), .out_valid(rov), .out_ready(rr),
            .s(rs), .cout(rcout)
        );

        initial begin
            logic [W:0] exp;
            int lat, tries;
            logic hs;
            sw_done[g] = 1'b0;
            rv = 1'b0; rr = 1'b0; ra = '0; rb = '0; rc = 1'b0;
            wait (sw_reset);
            @(negedge clock);
            for (int t = 0; t < 1000; t++) begin
                repeat ($urandom_range(0, 3)) @(negedge clock);
                ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
                exp = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
                rv = 1'b1;
                @(negedge clock);
                rv = 1'($urandom); ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
                lat = 1;
                while (!rov && lat < 80) begin
                    rr = 1'($urandom);
                    @(negedge clock);
                    lat++;
                end
                rv = 1'b0;
                check($sformatf("sweep w%0d c%0d latency t%0d", W, C, t), 64'(lat), 64'(N + 1));
                check($sformatf("sweep w%0d c%0d sum t%0d", W, C, t), 64'({rcout, rs}), 64'(exp));
                hs = 1'b0; tries = 0;
                while (!hs) begin
                    rr = (tries == 7) ? 1'b1 : 1'($urandom);
                    hs = rr;
                    @(negedge clock);
                    tries++;
                end
            end
            sw_done[g] = 1'b1;
        end
    end
endmodule
